mcs4_bus_ctl: RTL

- Bus controller and memory arbiter between the i4004 core and one shared byte-wide program memory port.
- Recovers the 8-phase instruction cycle from `sync` and assembles the 12-bit fetch address from the A1..A3 nibbles.
- Serves the opcode byte as two nibbles on M1/M2 and returns I/O read nibbles on X2.
- Shares the memory port with a host (PYNQ PS) requester, which gets every slot the CPU fetch does not need.

---
 rtl/mcs4_bus_ctl.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/mcs4_bus_ctl.sv
// i4004 bus controller: recovers the 8-phase cycle from sync, serves opcode fetches and shares the memory port with a host.
// Optional breakpoint unit enabled by defining MCS4_BUSCTL_BKPT_EN.
module mcs4_bus_ctl #(
  parameter int ADDR_W       = 12,
  parameter int DATA_W       = 8,
  parameter int SYNC_TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sync,
  input  logic              cm_rom,
  input  logic [3:0]        cm_ram,
  input  logic [3:0]        cpu_dbus_out,
  output logic [3:0]        cpu_dbus_in,
  input  logic [3:0]        io_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_gnt,
  output logic              host_rvalid,
  output logic [DATA_W-1:0] host_rdata,
  output logic              locked,
  output logic              sync_err,
`ifdef MCS4_BUSCTL_BKPT_EN
  input  logic [ADDR_W-1:0] bkpt_addr,
  input  logic              bkpt_arm,
`endif
  output logic              bkpt_hit
);

  typedef enum logic [2:0] {
    PH_A1 = 3'd0,
    PH_A2 = 3'd1,
    PH_A3 = 3'd2,
    PH_M1 = 3'd3,
    PH_M2 = 3'd4,
    PH_X1 = 3'd5,
    PH_X2 = 3'd6,
    PH_X3 = 3'd7
  } phase_t;

  localparam int CNT_W = $clog2(SYNC_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] TO_MAX = CNT_W'(SYNC_TIMEOUT);

  phase_t             phase, phase_nxt;
  logic [CNT_W-1:0]   to_cnt, to_cnt_nxt;
  logic               locked_q, sync_err_q;
  logic [7:0]         addr_lo;
  logic [ADDR_W-1:0]  fetch_addr;
  logic               cpu_fetch, fetch_m1;
  logic [3:0]         opbuf_lo;
  logic               io_cyc;
  logic               rd_pend;
  logic               cnt_rd, cnt_rd_pend;
  logic [DATA_W-1:0]  cnt_rdata;

  always_comb begin
    phase_nxt = phase_t'(phase + 3'd1);
    if (sync) phase_nxt = PH_A1;
  end

  // Timeout counter saturates so an unlocked core does not wrap it back into range.
  always_comb begin
    to_cnt_nxt = to_cnt;
    if (sync)
      to_cnt_nxt = '0;
    else if (to_cnt != TO_MAX)
      to_cnt_nxt = to_cnt + CNT_W'(1);
  end

  assign fetch_addr = ADDR_W'({cpu_dbus_out, addr_lo});
  assign cpu_fetch  = locked_q && (phase == PH_A3) && cm_rom && !rst;
  assign host_gnt   = host_req && !cpu_fetch && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      phase      <= PH_A1;
      to_cnt     <= '0;
      locked_q   <= 1'b0;
      sync_err_q <= 1'b0;
      addr_lo    <= 8'h00;
      fetch_m1   <= 1'b0;
      opbuf_lo   <= 4'h0;
      io_cyc     <= 1'b0;
      rd_pend    <= 1'b0;
    end else begin
      phase  <= phase_nxt;
      to_cnt <= to_cnt_nxt;
      if (sync) begin
        locked_q <= 1'b1;
      end else if (locked_q && (to_cnt_nxt == TO_MAX)) begin
        locked_q   <= 1'b0;
        sync_err_q <= 1'b1;
      end
      if (phase == PH_A1) addr_lo[3:0] <= cpu_dbus_out;
      if (phase == PH_A2) addr_lo[7:4] <= cpu_dbus_out;
      fetch_m1 <= cpu_fetch;
      // Loading zero on a non-fetch cycle makes M2 return 0 without a separate valid bit.
      if (phase == PH_M1) opbuf_lo <= fetch_m1 ? mem_rdata[3:0] : 4'h0;
      if (phase == PH_M2)
        io_cyc <= (cm_ram != 4'h0);
      else if (phase == PH_X3)
        io_cyc <= 1'b0;
      rd_pend <= host_gnt && !host_we && !cnt_rd;
    end
  end

  always_comb begin
    cpu_dbus_in = 4'h0;
    if (locked_q && !rst) begin
      case (phase)
        PH_M1:   if (fetch_m1) cpu_dbus_in = mem_rdata[7:4];
        PH_M2:   cpu_dbus_in = opbuf_lo;
        PH_X2:   if (io_cyc) cpu_dbus_in = io_rdata;
        default: cpu_dbus_in = 4'h0;
      endcase
    end
  end

  // CPU fetch always wins the port; the host only sees it when not held off.
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (cpu_fetch) begin
      mem_en   = 1'b1;
      mem_addr = fetch_addr;
    end else if (host_gnt && !cnt_rd) begin
      mem_en    = 1'b1;
      mem_we    = host_we;
      mem_addr  = host_addr;
      mem_wdata = host_wdata;
    end
  end

  assign host_rvalid = (rd_pend || cnt_rd_pend) && !rst;
  assign host_rdata  = !host_rvalid ? '0 : (cnt_rd_pend ? cnt_rdata : mem_rdata);
  assign locked      = locked_q;
  assign sync_err    = sync_err_q;

`ifdef MCS4_BUSCTL_BKPT_EN
  logic       bkpt_m1;
  logic [7:0] hit_cnt;

  assign cnt_rd    = host_gnt && !host_we && (host_addr == '1);
  assign cnt_rdata = DATA_W'(hit_cnt);
  assign bkpt_hit  = bkpt_m1 && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      bkpt_m1     <= 1'b0;
      hit_cnt     <= 8'h00;
      cnt_rd_pend <= 1'b0;
    end else begin
      bkpt_m1     <= cpu_fetch && bkpt_arm && (fetch_addr == bkpt_addr);
      cnt_rd_pend <= cnt_rd;
      if (bkpt_m1 && (hit_cnt != 8'hFF)) hit_cnt <= hit_cnt + 8'h01;
    end
  end
`else
  assign cnt_rd      = 1'b0;
  assign cnt_rd_pend = 1'b0;
  assign cnt_rdata   = '0;
  assign bkpt_hit    = 1'b0;
`endif

endmodule
